// File: rtl/counter_display_n.sv
// counter_display_n
// Multi-digit BCD/hex counter paced by an internal prescaler.
// It drives a time-multiplexed, active-low 7-segment display and can
// blank leading zeros.
//
// Parameters
//   DIGITS    number of 4-bit digits (1..8)
//   DIV_BITS  prescaler width; one count tick every 2^DIV_BITS clocks
//   SCAN_BITS scan timer width; display digit advances every 2^SCAN_BITS clocks
//   BCD       1: digits count 0-9, 0: digits count 0-F
//
// Ports
//   CLK  system clock, rising edge
//   RST  asynchronous active-high reset
//   EN   count enable, only looked at on tick cycles
//   S    mode: 00 hold, 01 up, 10 down, 11 load
//   D    load value, digit 0 in D[3:0]
//   LZB  1: blank leading zero digits
//   Q    current count, digit 0 in Q[3:0]
//   TC   one-clock terminal-count pulse on wrap (up or down)
//   SEG  segments a..g in SEG[0]..SEG[6], active-low
//   AN   digit enables, one-hot active-low
module counter_display_n #(
    parameter int DIGITS    = 4,
    parameter int DIV_BITS  = 10,
    parameter int SCAN_BITS = 8,
    parameter int BCD       = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [1:0]          S,
    input  logic [4*DIGITS-1:0] D,
    input  logic                LZB,
    output logic [4*DIGITS-1:0] Q,
    output logic                TC,
    output logic [6:0]          SEG,
    output logic [DIGITS-1:0]   AN
);

    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0]        DIG_MAX  = (BCD != 0) ? 4'd9 : 4'd15;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_RST   = ~(DIGITS'(1));

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Hex digit to active-low segment pattern (bit 0 = a).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] dig);
        logic [6:0] seg;
        case (dig)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [DIV_BITS-1:0]  presc_q, presc_d;
    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  count_q, count_d;
    logic                 tc_q, tc_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [6:0]           seg_q, seg_d;

    logic                 tick_s;
    logic [4*DIGITS-1:0]  up_s, dn_s, ld_s;
    logic                 up_carry_s, dn_borrow_s;
    logic                 hi_zero_s;
    logic [DIGITS-1:0]    blank_s;
    logic [3:0]           dig_sel_s;

    assign tick_s = &presc_q;

    // Candidate next counts for up, down and load; a carry/borrow that
    // survives every digit means the whole counter wraps.
    always_comb begin
        up_s        = '0;
        dn_s        = '0;
        ld_s        = '0;
        up_carry_s  = 1'b1;
        dn_borrow_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (up_carry_s) begin
                if (count_q[4*i +: 4] == DIG_MAX) begin
                    up_s[4*i +: 4] = 4'd0;
                end else begin
                    up_s[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    up_carry_s     = 1'b0;
                end
            end else begin
                up_s[4*i +: 4] = count_q[4*i +: 4];
            end

            if (dn_borrow_s) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dn_s[4*i +: 4] = DIG_MAX;
                end else begin
                    dn_s[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    dn_borrow_s    = 1'b0;
                end
            end else begin
                dn_s[4*i +: 4] = count_q[4*i +: 4];
            end

            // Out-of-range BCD load digits saturate so Q stays a valid BCD value.
            if ((BCD != 0) && (D[4*i +: 4] > 4'd9)) begin
                ld_s[4*i +: 4] = 4'd9;
            end else begin
                ld_s[4*i +: 4] = D[4*i +: 4];
            end
        end
    end

    // Prescaler and counter next state; EN and S only matter on tick cycles.
    always_comb begin
        presc_d = presc_q + DIV_BITS'(1);
        count_d = count_q;
        tc_d    = 1'b0;
        if (tick_s && EN) begin
            case (S)
                MODE_HOLD: begin
                    count_d = count_q;
                end
                MODE_UP: begin
                    count_d = up_s;
                    tc_d    = up_carry_s;
                end
                MODE_DOWN: begin
                    count_d = dn_s;
                    tc_d    = dn_borrow_s;
                end
                MODE_LOAD: begin
                    count_d = ld_s;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end else begin
            count_d = count_q;
        end
    end

    // Scan timer and digit index; the index steps when the timer rolls over.
    always_comb begin
        scan_d = scan_q + SCAN_BITS'(1);
        if (&scan_q) begin
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Display drive for the digit that becomes active on the next edge.
    // A digit is blanked when it and every digit above it are zero.
    always_comb begin
        hi_zero_s = 1'b1;
        blank_s   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero_s  = hi_zero_s & (count_q[4*i +: 4] == 4'd0);
            blank_s[i] = hi_zero_s & LZB;
        end
        blank_s[0] = 1'b0;
        dig_sel_s  = count_q[{idx_d, 2'b00} +: 4];
        an_d       = ~(DIGITS'(1) << idx_d);
        seg_d      = blank_s[idx_d] ? 7'h7F : hex_to_seg(dig_sel_s);
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
            an_q    <= AN_RST;
            seg_q   <= 7'h40;
        end else begin
            presc_q <= presc_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign Q   = count_q;
    assign TC  = tc_q;
    assign AN  = an_q;
    assign SEG = seg_q;

endmodule
